// File: rtl/idli_decode_queue_m.sv
// Instruction queue between SQI fetch and execute decode; pairs SP-form
// instructions with their trailing immediate. Optional IDLI_DQ_STATS_EN adds a stall counter.
module idli_decode_queue_m #(
    parameter int W     = 4,
    parameter int DEPTH = 2,
    localparam int PERIOD = 16 / W,
    localparam int CTR_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic             i_dq_gck,
    input  logic             i_dq_rst,
    input  logic [CTR_W-1:0] i_dq_ctr,
    input  logic [15:0]      i_dq_enc,
    input  logic             i_dq_enc_vld,
    output logic             o_dq_rdy,
    input  logic             i_dq_flush,
    input  logic             i_dq_pop,
    output logic             o_dq_vld,
    output logic [15:0]      o_dq_enc,
    output logic [15:0]      o_dq_imm,
    output logic             o_dq_has_imm,
`ifdef IDLI_DQ_STATS_EN
    output logic [15:0]      o_dq_stall_cnt,
`endif
    output logic [CNT_W-1:0] o_dq_cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [15:0]      enc_r     [DEPTH];
    logic [15:0]      imm_r     [DEPTH];
    logic             has_imm_r [DEPTH];
    logic             cmp_r     [DEPTH];
    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [CNT_W-1:0] cnt_r;
    logic             pend_r;

    logic             per_end_s;
    logic             needs_imm_s;
    logic             accept_s;
    logic             alloc_s;
    logic             pop_s;
    logic [PTR_W-1:0] pend_idx_s;
    logic [PTR_W-1:0] head_nxt_s;
    logic [PTR_W-1:0] tail_nxt_s;
    logic             rdy_s;
    logic             vld_s;
    logic [15:0]      enc_s;
    logic [15:0]      imm_s;
    logic             has_imm_s;

    // SP-form (C = F) needs an immediate, except the opcodes that reuse C = F as a register list.
    function automatic logic needs_imm(input logic [15:0] enc);
        logic [3:0] op;
        op = enc[15:12];
        return (enc[3:0] == 4'hF) && (op != 4'b1000) && (op != 4'b1001) && (op != 4'b1101);
    endfunction

    // Pointer wrap at DEPTH (not necessarily a power of two).
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Head-entry view and readiness, derived from state only.
    always_comb begin
        rdy_s     = pend_r || (cnt_r < CNT_W'(DEPTH));
        vld_s     = 1'b0;
        enc_s     = 16'h0000;
        imm_s     = 16'h0000;
        has_imm_s = 1'b0;
        if (cnt_r != '0) begin
            vld_s     = cmp_r[head_r];
            enc_s     = enc_r[head_r];
            imm_s     = has_imm_r[head_r] ? imm_r[head_r] : 16'h0000;
            has_imm_s = has_imm_r[head_r];
        end else begin
            vld_s     = 1'b0;
        end
    end

    // Period-end qualification of accept/pop and pointer arithmetic.
    always_comb begin
        per_end_s   = (i_dq_ctr == CTR_W'(PERIOD - 1));
        needs_imm_s = needs_imm(i_dq_enc);
        accept_s    = per_end_s && i_dq_enc_vld && rdy_s;
        alloc_s     = accept_s && !pend_r;
        pop_s       = per_end_s && i_dq_pop && vld_s;
        pend_idx_s  = (tail_r == '0) ? PTR_W'(DEPTH - 1) : tail_r - PTR_W'(1);
        head_nxt_s  = ptr_inc(head_r);
        tail_nxt_s  = ptr_inc(tail_r);
    end

    // Queue state: updates only in the period-end cycle; flush overrides accept and pop.
    always_ff @(posedge i_dq_gck) begin
        if (i_dq_rst) begin
            head_r <= '0;
            tail_r <= '0;
            cnt_r  <= '0;
            pend_r <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                enc_r[i]     <= 16'h0000;
                imm_r[i]     <= 16'h0000;
                has_imm_r[i] <= 1'b0;
                cmp_r[i]     <= 1'b0;
            end
        end else if (per_end_s) begin
            if (i_dq_flush) begin
                head_r <= '0;
                tail_r <= '0;
                cnt_r  <= '0;
                pend_r <= 1'b0;
            end else begin
                if (accept_s && pend_r) begin
                    imm_r[pend_idx_s] <= i_dq_enc;
                    cmp_r[pend_idx_s] <= 1'b1;
                    pend_r            <= 1'b0;
                end else if (alloc_s) begin
                    enc_r[tail_r]     <= i_dq_enc;
                    imm_r[tail_r]     <= 16'h0000;
                    has_imm_r[tail_r] <= needs_imm_s;
                    cmp_r[tail_r]     <= !needs_imm_s;
                    pend_r            <= needs_imm_s;
                    tail_r            <= tail_nxt_s;
                end
                if (pop_s) begin
                    head_r <= head_nxt_s;
                end
                cnt_r <= cnt_r + CNT_W'(alloc_s) - CNT_W'(pop_s);
            end
        end
    end

`ifdef IDLI_DQ_STATS_EN
    logic [15:0] stall_cnt_r;
    logic        stall_s;

    // A period end counts as a stall when execute has nothing complete to take.
    always_comb begin
        stall_s = !vld_s && ((cnt_r != '0) || pend_r || !i_dq_flush);
    end

    // Saturating stall counter, cleared only by reset.
    always_ff @(posedge i_dq_gck) begin
        if (i_dq_rst) begin
            stall_cnt_r <= 16'h0000;
        end else if (per_end_s && stall_s && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'h0001;
        end
    end

    assign o_dq_stall_cnt = stall_cnt_r;
`endif

    assign o_dq_rdy     = rdy_s;
    assign o_dq_vld     = vld_s;
    assign o_dq_enc     = enc_s;
    assign o_dq_imm     = imm_s;
    assign o_dq_has_imm = has_imm_s;
    assign o_dq_cnt     = cnt_r;

endmodule

// File: tb/tb_idli_decode_queue_m.sv
// Scoreboard bench for idli_decode_queue_m: a W=4 and a W=1 instance, both DEPTH=2.
module tb_idli_decode_queue_m;

    typedef struct {
        bit          d;
        string       nm;
        int          at;
        logic        vld;
        logic [15:0] enc;
        logic [15:0] imm;
        logic        has;
        logic [1:0]  cnt;
        logic        rdy;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    exp_t q[$];

    // W=4 instance signals
    logic [1:0]  ctr4 = 2'd0;
    logic        rst4 = 1'b1;
    logic [15:0] enc4 = 16'h0000;
    logic        ev4 = 1'b0, pop4 = 1'b0, fl4 = 1'b0;
    logic        rdy4, vld4, has4;
    logic [15:0] oenc4, oimm4;
    logic [1:0]  cnt4;

    // W=1 instance signals
    logic [3:0]  ctr1 = 4'd0;
    logic        rst1 = 1'b1;
    logic [15:0] enc1 = 16'h0000;
    logic        ev1 = 1'b0, pop1 = 1'b0, fl1 = 1'b0;
    logic        rdy1, vld1, has1;
    logic [15:0] oenc1, oimm1;
    logic [1:0]  cnt1;

`ifdef IDLI_DQ_STATS_EN
    logic [15:0] st4, st1;
`endif

    idli_decode_queue_m #(.W(4), .DEPTH(2)) dut4 (
        .i_dq_gck(clk), .i_dq_rst(rst4), .i_dq_ctr(ctr4), .i_dq_enc(enc4),
        .i_dq_enc_vld(ev4), .o_dq_rdy(rdy4), .i_dq_flush(fl4), .i_dq_pop(pop4),
        .o_dq_vld(vld4), .o_dq_enc(oenc4), .o_dq_imm(oimm4), .o_dq_has_imm(has4),
`ifdef IDLI_DQ_STATS_EN
        .o_dq_stall_cnt(st4),
`endif
        .o_dq_cnt(cnt4)
    );

    idli_decode_queue_m #(.W(1), .DEPTH(2)) dut1 (
        .i_dq_gck(clk), .i_dq_rst(rst1), .i_dq_ctr(ctr1), .i_dq_enc(enc1),
        .i_dq_enc_vld(ev1), .o_dq_rdy(rdy1), .i_dq_flush(fl1), .i_dq_pop(pop1),
        .o_dq_vld(vld1), .o_dq_enc(oenc1), .o_dq_imm(oimm1), .o_dq_has_imm(has1),
`ifdef IDLI_DQ_STATS_EN
        .o_dq_stall_cnt(st1),
`endif
        .o_dq_cnt(cnt1)
    );

    // Monitor: compare outputs against every expectation due this cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].at == cyc) begin
            exp_t e;
            logic        a_vld, a_has, a_rdy;
            logic [15:0] a_enc, a_imm;
            logic [1:0]  a_cnt;
            e = q.pop_front();
            if (e.d) begin
                a_vld = vld1; a_enc = oenc1; a_imm = oimm1; a_has = has1; a_cnt = cnt1; a_rdy = rdy1;
            end else begin
                a_vld = vld4; a_enc = oenc4; a_imm = oimm4; a_has = has4; a_cnt = cnt4; a_rdy = rdy4;
            end
            checks++;
            if (a_vld !== e.vld || a_enc !== e.enc || a_imm !== e.imm ||
                a_has !== e.has || a_cnt !== e.cnt || a_rdy !== e.rdy) begin
                errors++;
                $display("FAIL %s: got vld=%b enc=%h imm=%h has=%b cnt=%0d rdy=%b, want vld=%b enc=%h imm=%h has=%b cnt=%0d rdy=%b",
                         e.nm, a_vld, a_enc, a_imm, a_has, a_cnt, a_rdy,
                         e.vld, e.enc, e.imm, e.has, e.cnt, e.rdy);
            end
        end
    end

    task automatic cyc1();
        @(posedge clk);
        #1;
        cyc++;
        ctr4 = ctr4 + 2'd1;
        ctr1 = ctr1 + 4'd1;
    endtask

    task automatic expect_s(input bit d, input string nm, input logic v, input logic [15:0] e,
                            input logic [15:0] i, input logic h, input logic [1:0] c, input logic r);
        exp_t x;
        x.d = d; x.nm = nm; x.at = cyc; x.vld = v; x.enc = e; x.imm = i; x.has = h; x.cnt = c; x.rdy = r;
        q.push_back(x);
    endtask

    task automatic pe4(input logic [15:0] w, input logic v, input logic p, input logic f);
        while (ctr4 != 2'd3) cyc1();
        enc4 = w; ev4 = v; pop4 = p; fl4 = f;
        cyc1();
        enc4 = 16'h0000; ev4 = 1'b0; pop4 = 1'b0; fl4 = 1'b0;
    endtask

    task automatic goto1(input logic [3:0] c);
        while (ctr1 != c) cyc1();
    endtask

    initial begin
        cyc1();
        rst4 = 1'b0; rst1 = 1'b0;
        expect_s(0, "reset4", 1'b0, 16'h0000, 16'h0000, 1'b0, 2'd0, 1'b1);
        expect_s(1, "reset1", 1'b0, 16'h0000, 16'h0000, 1'b0, 2'd0, 1'b1);

        pe4(16'h0123, 1'b1, 1'b0, 1'b0);
        expect_s(0, "push_plain", 1'b1, 16'h0123, 16'h0000, 1'b0, 2'd1, 1'b1);
        pe4(16'h0000, 1'b0, 1'b1, 1'b0);
        expect_s(0, "pop_plain", 1'b0, 16'h0000, 16'h0000, 1'b0, 2'd0, 1'b1);

        pe4(16'h012F, 1'b1, 1'b0, 1'b0);
        expect_s(0, "push_sp", 1'b0, 16'h012F, 16'h0000, 1'b1, 2'd1, 1'b1);
        pe4(16'h0000, 1'b0, 1'b1, 1'b0);
        expect_s(0, "pop_incomplete", 1'b0, 16'h012F, 16'h0000, 1'b1, 2'd1, 1'b1);
        pe4(16'hBEEF, 1'b1, 1'b0, 1'b0);
        expect_s(0, "push_imm", 1'b1, 16'h012F, 16'hBEEF, 1'b1, 2'd1, 1'b1);
        pe4(16'h0000, 1'b0, 1'b1, 1'b0);
        expect_s(0, "pop_sp", 1'b0, 16'h0000, 16'h0000, 1'b0, 2'd0, 1'b1);

        pe4(16'h801F, 1'b1, 1'b0, 1'b0);
        expect_s(0, "push_ldm", 1'b1, 16'h801F, 16'h0000, 1'b0, 2'd1, 1'b1);
        pe4(16'h1111, 1'b1, 1'b0, 1'b0);
        expect_s(0, "fill", 1'b1, 16'h801F, 16'h0000, 1'b0, 2'd2, 1'b0);
        pe4(16'h2222, 1'b1, 1'b1, 1'b0);
        expect_s(0, "full_pop_push", 1'b1, 16'h1111, 16'h0000, 1'b0, 2'd1, 1'b1);
        pe4(16'h2222, 1'b1, 1'b0, 1'b0);
        expect_s(0, "refill", 1'b1, 16'h1111, 16'h0000, 1'b0, 2'd2, 1'b0);
        pe4(16'h0000, 1'b0, 1'b1, 1'b0);
        expect_s(0, "pop_1111", 1'b1, 16'h2222, 16'h0000, 1'b0, 2'd1, 1'b1);
        pe4(16'h0000, 1'b0, 1'b1, 1'b0);
        expect_s(0, "pop_2222", 1'b0, 16'h0000, 16'h0000, 1'b0, 2'd0, 1'b1);

        pe4(16'h012F, 1'b1, 1'b0, 1'b0);
        pe4(16'hABCD, 1'b1, 1'b0, 1'b1);
        expect_s(0, "flush_pending", 1'b0, 16'h0000, 16'h0000, 1'b0, 2'd0, 1'b1);
        pe4(16'h3333, 1'b1, 1'b0, 1'b0);
        expect_s(0, "post_flush", 1'b1, 16'h3333, 16'h0000, 1'b0, 2'd1, 1'b1);
        pe4(16'h0000, 1'b0, 1'b1, 1'b0);

        pe4(16'h1111, 1'b1, 1'b0, 1'b0);
        pe4(16'h012F, 1'b1, 1'b0, 1'b0);
        expect_s(0, "full_pending_rdy", 1'b1, 16'h1111, 16'h0000, 1'b0, 2'd2, 1'b1);
        pe4(16'hBEEF, 1'b1, 1'b0, 1'b0);
        expect_s(0, "full_complete", 1'b1, 16'h1111, 16'h0000, 1'b0, 2'd2, 1'b0);
        pe4(16'h0000, 1'b0, 1'b1, 1'b0);
        expect_s(0, "wrap_head_sp", 1'b1, 16'h012F, 16'hBEEF, 1'b1, 2'd1, 1'b1);
        pe4(16'h0000, 1'b0, 1'b1, 1'b0);
        expect_s(0, "wrap_empty", 1'b0, 16'h0000, 16'h0000, 1'b0, 2'd0, 1'b1);

        goto1(4'd3);
        enc1 = 16'h5555; ev1 = 1'b1; pop1 = 1'b1;
        cyc1();
        enc1 = 16'h0000; ev1 = 1'b0; pop1 = 1'b0;
        expect_s(1, "w1_offperiod", 1'b0, 16'h0000, 16'h0000, 1'b0, 2'd0, 1'b1);
        goto1(4'd15);
        enc1 = 16'h012F; ev1 = 1'b1;
        cyc1();
        enc1 = 16'h0000; ev1 = 1'b0;
        expect_s(1, "w1_push_sp", 1'b0, 16'h012F, 16'h0000, 1'b1, 2'd1, 1'b1);
        goto1(4'd5);
        fl1 = 1'b1;
        cyc1();
        fl1 = 1'b0;
        expect_s(1, "w1_flush_off", 1'b0, 16'h012F, 16'h0000, 1'b1, 2'd1, 1'b1);
        goto1(4'd7);
        rst1 = 1'b1;
        cyc1();
        rst1 = 1'b0;
        expect_s(1, "w1_midreset", 1'b0, 16'h0000, 16'h0000, 1'b0, 2'd0, 1'b1);
        goto1(4'd15);
        enc1 = 16'h0123; ev1 = 1'b1;
        cyc1();
        enc1 = 16'h0000; ev1 = 1'b0;
        expect_s(1, "w1_push_plain", 1'b1, 16'h0123, 16'h0000, 1'b0, 2'd1, 1'b1);

        cyc1();
        cyc1();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d unchecked expectations, want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
